// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if: control, load and status signals of the up/down modulo counter
interface updown_mod_counter_if #(parameter int N = 3);
  logic         en;
  logic         down;
  logic         load;
  logic [N-1:0] d;
  logic [N-1:0] q;
  logic         tc;
  logic         wrap;
  modport master (output en, down, load, d, input q, tc, wrap);
  modport slave  (input en, down, load, d, output q, tc, wrap);
endinterface

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down counter modulo MODULUS with load, wrap or saturate, tc and wrap flags
module updown_mod_counter #(
  parameter int N        = 3,
  parameter int MODULUS  = 2**N,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  updown_mod_counter_if.slave bus
);
  if (N < 2 || MODULUS < 2 || MODULUS > 2**N) begin : g_bad_param
    $error("updown_mod_counter: illegal N/MODULUS");
  end
  localparam logic [N-1:0] MAX = N'(MODULUS - 1);
  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         at_end;
  logic [N-1:0] load_val;
  logic [N-1:0] end_val;
  always_comb begin
    at_end   = bus.down ? (q_q == '0) : (q_q == MAX);
    load_val = (bus.d > MAX) ? MAX : bus.d;
    end_val  = SATURATE ? q_q : (bus.down ? MAX : '0);
    q_d      = rst ? '0 :
               bus.load ? load_val :
               !bus.en ? q_q :
               at_end ? end_val :
               bus.down ? q_q - 1'b1 : q_q + 1'b1;
    wrap_d   = !rst && !bus.load && bus.en && at_end && !SATURATE;
  end
  always_ff @(posedge clk) begin
    q_q    <= q_d;
    wrap_q <= wrap_d;
  end
  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = !rst && bus.en && !bus.load && at_end;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: directed checks of wrap, modulo, saturate, load, reset and direction behaviour
module tb_updown_mod_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  updown_mod_counter_if #(.N(3)) ba ();
  updown_mod_counter_if #(.N(3)) bb ();
  updown_mod_counter_if #(.N(3)) bc ();
  updown_mod_counter #(.N(3), .MODULUS(8), .SATURATE(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ba.slave));
  updown_mod_counter #(.N(3), .MODULUS(6), .SATURATE(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bb.slave));
  updown_mod_counter #(.N(3), .MODULUS(6), .SATURATE(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(bc.slave));
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    ba.en = 0; ba.down = 0; ba.load = 0; ba.d = 0;
    bb.en = 0; bb.down = 0; bb.load = 0; bb.d = 0;
    bc.en = 0; bc.down = 0; bc.load = 0; bc.d = 0;
    rst = 1; ba.en = 1;
    step();
    chk("rst_q", ba.q, 0);
    chk("rst_wrap", ba.wrap, 0);
    chk("rst_tc", ba.tc, 0);
    chk("rst_qb", bb.q, 0);
    rst = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("t1_q%0d", k), ba.q, k % 8);
      chk($sformatf("t1_wrap%0d", k), ba.wrap, (k == 8) ? 1 : 0);
      chk($sformatf("t1_tc%0d", k), ba.tc, (k == 7) ? 1 : 0);
    end
    ba.en = 0;
    bb.en = 1; bb.down = 1;
    #1;
    chk("t2_tc_q0", bb.tc, 1);
    step();
    chk("t2_q5", bb.q, 5);
    chk("t2_wrap5", bb.wrap, 1);
    chk("t2_tc5", bb.tc, 0);
    step();
    chk("t2_q4", bb.q, 4);
    chk("t2_wrap4", bb.wrap, 0);
    chk("t2_tc4", bb.tc, 0);
    step();
    chk("t2_q3", bb.q, 3);
    chk("t2_wrap3", bb.wrap, 0);
    bb.en = 0; bb.down = 0;
    bc.load = 1; bc.d = 3; bc.en = 1;
    #1;
    chk("t3_tc_load", bc.tc, 0);
    step();
    chk("t3_load", bc.q, 3);
    bc.load = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("t3_q%0d", k), bc.q, (k == 1) ? 4 : 5);
      chk($sformatf("t3_tc%0d", k), bc.tc, (k == 1) ? 0 : 1);
      chk($sformatf("t3_wrap%0d", k), bc.wrap, 0);
    end
    bc.en = 0;
    bb.load = 1; bb.d = 7;
    step();
    chk("t4_clamp", bb.q, 5);
    chk("t4_wrap", bb.wrap, 0);
    bb.en = 1; bb.down = 0; bb.d = 2;
    #1;
    chk("t4_tc_load", bb.tc, 0);
    step();
    chk("t4_load_en", bb.q, 2);
    bb.en = 0; bb.d = 4;
    step();
    chk("t5_pre", bb.q, 4);
    rst = 1; bb.load = 1; bb.en = 1; bb.d = 3;
    step();
    chk("t5_rst_q", bb.q, 0);
    chk("t5_rst_wrap", bb.wrap, 0);
    rst = 0; bb.load = 0; bb.en = 1; bb.down = 0;
    step();
    chk("t5_after", bb.q, 1);
    bb.load = 1; bb.en = 0; bb.d = 2;
    step();
    chk("t6_load", bb.q, 2);
    bb.load = 0; bb.en = 1;
    for (int k = 0; k < 4; k++) begin
      bb.down = k[0];
      step();
      chk($sformatf("t6_q%0d", k), bb.q, k[0] ? 2 : 3);
    end
    bb.en = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t6_hold_q%0d", k), bb.q, 2);
      chk($sformatf("t6_hold_tc%0d", k), bb.tc, 0);
      chk($sformatf("t6_hold_wrap%0d", k), bb.wrap, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
